mem_ctrl: RTL
=============

# mem_ctrl

Memory controller between the IF/MEM pipeline stages and the byte-wide unified RAM port. Arbitrates instruction fetches against data loads and stores, serialises each access into byte transfers, and raises `stallreq_from_if` / `stallreq_from_mem` toward the stall controller until each request completes. It produces the stall requests that the stall controller turns into the 6-bit stall vector.

## Interface
- `ICACHE_ENTRIES`, 64: direct-mapped I-cache lines, one word each; power of two. Used only with `ICACHE_EN`.
- `clk_in` input 1: clock.
- `rst_in` input 1: synchronous reset, active-high.
- `rdy_in` input 1: global ready; low freezes all state.
- `if_req` input 1: instruction fetch request, held until `if_done`.
- `if_addr` input 32: fetch address, word-aligned.
- `if_done` output 1: one-cycle pulse, `if_data` valid.
- `if_data` output 32: fetched instruction.
- `mem_req` input 1: data access request, held until `mem_done`.
- `mem_we` input 1: 1 = store, 0 = load.
- `mem_len` input 3: byte count, 1, 2 or 4.
- `mem_addr` input 32: data address.
- `mem_wdata` input 32: store data, little-endian, low bytes first.
- `mem_done` output 1: one-cycle pulse, `mem_rdata` valid for loads.
- `mem_rdata` output 32: load data, zero-extended; sign extension is done in MEM.
- `ram_din` input 8: RAM read byte, valid one cycle after address.
- `ram_dout` output 8: RAM write byte.
- `ram_a` output 32: RAM byte address.
- `ram_wr` output 1: 1 = write this cycle.
- `stallreq_from_if` output 1: `if_req & ~if_done`, combinational.
- `stallreq_from_mem` output 1: `mem_req & ~mem_done`, combinational.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
  - IDLE: if `mem_req`, go to MEM_RD or MEM_WR. Otherwise, if `if_req`, go to IF_RD.
  - Busy states return to IDLE on the done edge.
- MEM has priority over IF at acceptance only. A transaction in progress is never preempted.
- Byte counter: 3 bits. Byte i uses address base+i; 32-bit address arithmetic wraps modulo 2^32.
- Read: byte i is sampled from `ram_din` into bits [8i+7:8i]. Unfilled high bytes are 0.
- Write: byte i is `mem_wdata[8i+7:8i]`, driven with `ram_wr`=1.
- If `if_req` drops mid-IF_RD (branch flush), the transaction completes but `if_done` is suppressed. The next IDLE cycle re-arbitrates.
- IF addresses come from a single requester, so no same-address ordering hazards exist. MEM stays stalled while IF is busy.
- `rdy_in`=0: counters, state, RAM outputs and done pulses hold; `ram_wr` is forced to 0.
- Reset values: state IDLE; counter 0; `if_done`, `mem_done`, `ram_wr` = 0; `ram_a`, `ram_dout`, `if_data`, `mem_rdata` = 0. Reset mid-transaction aborts it with no done pulse.

## Timing
- Acceptance edge T0 is the edge at which IDLE samples a request.
- Read of n bytes:
  - `ram_a` = base+i during the cycle after T0+i, for i = 0 to n-1.
  - Byte i is sampled at T0+i+2.
  - Done is high in the cycle after T0+n+1; a 4-byte read gives done in the cycle after T0+5.
- Write of n bytes: byte i is written in the cycle after T0+i. Done is high in the cycle after T0+n.
- The done pulse lasts exactly one cycle. The next acceptance can occur at the done edge +1, giving one IDLE cycle between transactions.

## Configuration
- `ICACHE_EN` defined:
  - Direct-mapped I-cache with index `if_addr[log2(ICACHE_ENTRIES)+1:2]`, remaining upper bits as tag, and a valid bit per line.
  - IF hit in IDLE (with no `mem_req`): `if_done` in the cycle after T0, no RAM traffic.
  - Every completed IF_RD fills its line.
  - A MEM_WR invalidates the line indexed by `mem_addr`.
  - Reset clears all valid bits.
- `ICACHE_EN` not defined: every fetch goes to RAM; no cache storage is synthesised.

## Structure
- The shared defines package holds `RstEnable`, `Stop`/`NoStop`, the state encoding, and the widths for address (32), data (32) and RAM data (8).
- Sub-module `icache` (tag/valid/data arrays, hit and fill ports) is instantiated only under `ICACHE_EN`.

## Test plan
- Reset, then `if_req` at 0x00000004 with RAM bytes 13,00,50,00 at 0x4 to 0x7 -> `if_data`=0x00500013, `if_done` in the cycle after T0+5, `stallreq_from_if` high until then.
- `mem_req` store `mem_len`=2, `mem_wdata`=0xAABBCCDD at 0x100 -> `ram_wr` on 0x100=0xDD and 0x101=0xCC only; `mem_done` in the cycle after T0+2.
- `if_req` and `mem_req` in the same IDLE cycle -> MEM serviced first, then IF; `stallreq_from_if` stays high throughout.
- `if_req` dropped in the second IF_RD cycle -> no `if_done`; controller back in IDLE in the cycle after T0+5.
- `rdy_in`=0 for 3 cycles mid 4-byte load -> done delayed by exactly 3 cycles, data unchanged.
- `ICACHE_EN`: fetch 0x4 twice -> second `if_done` in the cycle after T0 with no `ram_a` change; store to 0x4, then fetch -> miss and RAM read.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared defines for the memory controller slice.
// Holds reset/stall encodings, bus widths, the FSM state type, the
// in-flight transfer record and byte-lane helpers.
package mem_ctrl_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RAM_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_e;

    // One in-flight transfer: base address, byte count, edge counter and
    // a sticky flag set when the fetch requester abandons the fetch.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [2:0]        len;
        logic [2:0]        cnt;
        logic              flush;
    } xfer_t;

    function automatic logic [RAM_W-1:0] get_byte(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] idx);
        return w[{idx, 3'b000} +: RAM_W];
    endfunction

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0] idx,
                                                   input logic [RAM_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = w;
        r[{idx, 3'b000} +: RAM_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, data-access and byte-RAM bus bundle.
// slave = controller side, master = pipeline/RAM side.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_data;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic [RAM_W-1:0]  ram_din;
    logic [RAM_W-1:0]  ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              stallreq_from_if;
    logic              stallreq_from_mem;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               stallreq_from_if, stallreq_from_mem
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               stallreq_from_if, stallreq_from_mem
    );

endinterface

// File: rtl/mem_ctrl_icache.sv
// icache: direct-mapped one-word-per-line instruction cache (used only
// when ICACHE_EN is defined). Addresses arrive as word addresses.
module icache
    import mem_ctrl_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-3:0] rd_waddr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-3:0] fill_waddr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx
);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tags;
    logic [ENTRIES-1:0][DATA_W-1:0] data;

    logic [IDX_W-1:0] rd_idx, fill_idx;
    assign rd_idx   = rd_waddr[IDX_W-1:0];
    assign fill_idx = fill_waddr[IDX_W-1:0];

    assign hit      = valid[rd_idx] && (tags[rd_idx] == rd_waddr[ADDR_W-3:IDX_W]);
    assign hit_data = data[rd_idx];

    // Line fill on completed fetch, invalidate on store; only valids reset.
    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            valid <= '0;
        end else if (rdy_in) begin
            if (fill_en) begin
                valid[fill_idx] <= 1'b1;
                tags[fill_idx]  <= fill_waddr[ADDR_W-3:IDX_W];
                data[fill_idx]  <= fill_data;
            end
            if (inv_en) valid[inv_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF fetches and MEM loads/stores onto a byte-wide
// RAM port, one byte per cycle, and raises stall requests until done.
// Optional I-cache: define ICACHE_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ICACHE_ENTRIES = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    mem_ctrl_if.slave  bus
);
    state_e            state, state_n;
    xfer_t             xf;
    logic              acc_if, acc_mr, acc_mw, hit_go, fin;
    logic              if_done_q, mem_done_q, wr_q, rdy_q;
    logic [DATA_W-1:0] if_data_q, mem_rdata_q, rd_word;
    logic [ADDR_W-1:0] ram_a_q;
    logic [RAM_W-1:0]  dout_q, din_hold, rd_byte;
    logic [2:0]        cnt_inc;
    logic [1:0]        rd_idx;
    logic              ic_hit;
    logic [DATA_W-1:0] ic_data;

    assign cnt_inc = xf.cnt + 3'd1;
    assign rd_idx  = xf.cnt[1:0] - 2'd1;
    // After a freeze the RAM byte has moved on to the held address, so the
    // byte seen just before the freeze is replayed on the resume edge.
    assign rd_byte = rdy_q ? bus.ram_din : din_hold;
    assign rd_word = put_byte((state == IF_RD) ? if_data_q : mem_rdata_q, rd_idx, rd_byte);

    assign bus.if_done           = if_done_q;
    assign bus.if_data           = if_data_q;
    assign bus.mem_done          = mem_done_q;
    assign bus.mem_rdata         = mem_rdata_q;
    assign bus.ram_a             = ram_a_q;
    assign bus.ram_dout          = dout_q;
    assign bus.ram_wr            = wr_q & rdy_in;
    assign bus.stallreq_from_if  = (bus.if_req & ~if_done_q) ? Stop : NoStop;
    assign bus.stallreq_from_mem = (bus.mem_req & ~mem_done_q) ? Stop : NoStop;

    // State register; frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) state <= IDLE;
        else if (rdy_in)         state <= state_n;
    end

    // Arbitration (MEM wins at acceptance) and completion detection.
    always_comb begin
        state_n = state;
        acc_if  = 1'b0;
        acc_mr  = 1'b0;
        acc_mw  = 1'b0;
        hit_go  = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    state_n = bus.mem_we ? MEM_WR : MEM_RD;
                    acc_mr  = ~bus.mem_we;
                    acc_mw  = bus.mem_we;
                end else if (bus.if_req) begin
                    if (ic_hit) begin
                        hit_go = 1'b1;
                    end else begin
                        state_n = IF_RD;
                        acc_if  = 1'b1;
                    end
                end
            end
            // Reads finish one edge after the last byte address (RAM latency).
            IF_RD, MEM_RD: begin
                if (xf.cnt == xf.len) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            MEM_WR: begin
                if (cnt_inc == xf.len) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte sequencing: address/data issue, read assembly and done pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            xf          <= '0;
            ram_a_q     <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else if (rdy_in) begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if (acc_if | acc_mr | acc_mw) begin
                xf.base  <= acc_if ? bus.if_addr : bus.mem_addr;
                xf.len   <= acc_if ? 3'd4 : bus.mem_len;
                xf.cnt   <= 3'd0;
                xf.flush <= 1'b0;
                ram_a_q  <= acc_if ? bus.if_addr : bus.mem_addr;
                if (acc_if) if_data_q   <= '0;
                if (acc_mr) mem_rdata_q <= '0;
                if (acc_mw) begin
                    dout_q <= get_byte(bus.mem_wdata, 2'd0);
                    wr_q   <= 1'b1;
                end
            end
            if (hit_go) begin
                if_done_q <= 1'b1;
                if_data_q <= ic_data;
            end
            case (state)
                IF_RD, MEM_RD: begin
                    xf.cnt <= cnt_inc;
                    if (cnt_inc < xf.len) ram_a_q <= xf.base + ADDR_W'(cnt_inc);
                    if (xf.cnt != 3'd0) begin
                        if (state == IF_RD) if_data_q   <= rd_word;
                        else                mem_rdata_q <= rd_word;
                    end
                    if (state == IF_RD && !bus.if_req) xf.flush <= 1'b1;
                    if (fin) begin
                        if (state == IF_RD) if_done_q  <= bus.if_req & ~xf.flush;
                        else                mem_done_q <= 1'b1;
                    end
                end
                MEM_WR: begin
                    xf.cnt <= cnt_inc;
                    if (fin) begin
                        wr_q       <= 1'b0;
                        mem_done_q <= 1'b1;
                    end else begin
                        ram_a_q <= xf.base + ADDR_W'(cnt_inc);
                        dout_q  <= get_byte(bus.mem_wdata, cnt_inc[1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tracks rdy_in and keeps the last RAM byte seen before a freeze.
    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            rdy_q    <= 1'b0;
            din_hold <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (rdy_q) din_hold <= bus.ram_din;
        end
    end

`ifdef ICACHE_EN
    localparam int IC_IDX_W = $clog2(ICACHE_ENTRIES);

    icache #(.ENTRIES(ICACHE_ENTRIES), .IDX_W(IC_IDX_W)) u_icache (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rd_waddr   (bus.if_addr[ADDR_W-1:2]),
        .hit        (ic_hit),
        .hit_data   (ic_data),
        .fill_en    (fin && (state == IF_RD)),
        .fill_waddr (xf.base[ADDR_W-1:2]),
        .fill_data  (rd_word),
        .inv_en     (acc_mw),
        .inv_idx    (bus.mem_addr[IC_IDX_W+1:2])
    );
`else
    assign ic_hit  = 1'b0;
    assign ic_data = '0;

    generate
        if ((ICACHE_ENTRIES & (ICACHE_ENTRIES - 1)) != 0) begin : g_bad_entries
            $error("ICACHE_ENTRIES must be a power of two");
        end
    endgenerate
`endif

endmodule
